// File: rtl/uart_reply_arbiter.sv
// uart_reply_arbiter
//   Merges reply traffic from two slave-side UART receivers onto one host-side
//   UART transmitter. Each slave's bytes are buffered in a private FIFO and
//   sent as packets: header {src[1:0], len[5:0]} then len data bytes
//   (src 2'b00 = slave 1, 2'b01 = slave 2). Channels are served round-robin.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   s1_rx_dv, s1_rx_byte     slave-1 byte strobe / data
//   s2_rx_dv, s2_rx_byte     slave-2 byte strobe / data
//   tx_busy                  host UART_TX is shifting a byte
//   tx_dv, tx_byte           one-cycle start strobe / byte to host UART_TX
//   grant                    01 = ch1 owns link, 10 = ch2 owns link, 00 = idle
//   s1_overflow, s2_overflow sticky: a byte was dropped on a full FIFO
module uart_reply_arbiter #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned MAX_LEN    = 16,
    parameter int unsigned IDLE_CLKS  = 10410
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s1_rx_dv,
    input  logic [7:0] s1_rx_byte,
    input  logic       s2_rx_dv,
    input  logic [7:0] s2_rx_byte,
    input  logic       tx_busy,
    output logic       tx_dv,
    output logic [7:0] tx_byte,
    output logic [1:0] grant,
    output logic       s1_overflow,
    output logic       s2_overflow
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned IW = $clog2(IDLE_CLKS + 1);

    typedef enum logic [1:0] {StIdle, StHdr, StGap, StData} state_e;

    logic [1:0]    rx_dv;
    logic [7:0]    rx_byte [2];
    logic [CW-1:0] count   [2];
    logic [7:0]    head    [2];
    logic [1:0]    ready;
    logic [1:0]    pop;
    logic [1:0]    overflow;

    assign rx_dv      = {s2_rx_dv, s1_rx_dv};
    assign rx_byte[0] = s1_rx_byte;
    assign rx_byte[1] = s2_rx_byte;

    // Per-channel FIFO, idle timer and ready detection
    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [7:0]    mem_q [FIFO_DEPTH];
        logic [AW-1:0] wr_ptr_q;
        logic [AW-1:0] rd_ptr_q;
        logic [CW-1:0] count_q;
        logic [IW-1:0] idle_q;
        logic          ovf_q;
        logic          push;

        // A full FIFO still accepts a byte when the head leaves in the same cycle
        assign push = rx_dv[c] && ((count_q != CW'(FIFO_DEPTH)) || pop[c]);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                idle_q   <= '0;
                ovf_q    <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop[c]) rd_ptr_q <= rd_ptr_q + AW'(1);
                if (push && !pop[c]) begin
                    count_q <= count_q + CW'(1);
                end else if (!push && pop[c]) begin
                    count_q <= count_q - CW'(1);
                end
                if (rx_dv[c] && !push) ovf_q <= 1'b1;
                if (rx_dv[c]) begin
                    idle_q <= '0;
                end else if (idle_q != IW'(IDLE_CLKS)) begin
                    idle_q <= idle_q + IW'(1);
                end
            end
        end

        // Storage needs no reset: pointers and count define what is valid
        always_ff @(posedge clk) begin
            if (push) mem_q[wr_ptr_q] <= rx_byte[c];
        end

        assign count[c]    = count_q;
        assign head[c]     = mem_q[rd_ptr_q];
        assign overflow[c] = ovf_q;
        assign ready[c]    = (count_q >= CW'(MAX_LEN)) ||
                             ((count_q != '0) && (idle_q == IW'(IDLE_CLKS)));
    end

    assign s1_overflow = overflow[0];
    assign s2_overflow = overflow[1];

    // Packet FSM. chan_q doubles as the round-robin pointer: it holds the last
    // granted channel, so resetting it to ch2 makes ch1 win the first tie.
    state_e     state_q, state_d;
    logic       chan_q, chan_d;
    logic [5:0] remain_q, remain_d;
    logic       tx_dv_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic       sel;
    logic [5:0] sel_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            chan_q    <= 1'b1;
            remain_q  <= '0;
            tx_dv     <= 1'b0;
            tx_byte_q <= '0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            remain_q  <= remain_d;
            tx_dv     <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    assign tx_byte = tx_byte_q;

    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        remain_d = remain_q;
        sel      = (ready == 2'b11) ? ~chan_q : ready[1];
        sel_len  = (count[sel] >= CW'(MAX_LEN)) ? 6'(MAX_LEN) : 6'(count[sel]);
        unique case (state_q)
            StIdle: begin
                if (ready != 2'b00) begin
                    state_d  = StHdr;
                    chan_d   = sel;
                    remain_d = sel_len;
                end
            end
            StHdr: begin
                if (!tx_busy) state_d = StGap;
            end
            // Covers the cycle before UART_TX reflects the new byte on tx_busy
            StGap: begin
                state_d = (remain_q != '0) ? StData : StIdle;
            end
            StData: begin
                if (!tx_busy) begin
                    state_d  = StGap;
                    remain_d = remain_q - 6'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        pop       = 2'b00;
        grant     = (state_q == StIdle) ? 2'b00 : (chan_q ? 2'b10 : 2'b01);
        unique case (state_q)
            StHdr: begin
                if (!tx_busy) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = {1'b0, chan_q, remain_q};
                end
            end
            StData: begin
                if (!tx_busy) begin
                    tx_dv_d     = 1'b1;
                    tx_byte_d   = head[chan_q];
                    pop[chan_q] = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_reply_arbiter.sv
// Testbench for uart_reply_arbiter. Bit timing is scaled down (40 clks/bit,
// 400-clk idle flush) so the whole run stays short.
module tb_uart_reply_arbiter;
    localparam int unsigned FD  = 16;
    localparam int unsigned ML  = 16;
    localparam int unsigned IC  = 400;
    localparam int unsigned BIT = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s1_rx_dv = 1'b0;
    logic [7:0] s1_rx_byte = 8'h00;
    logic       s2_rx_dv = 1'b0;
    logic [7:0] s2_rx_byte = 8'h00;
    logic       tx_busy;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic [1:0] grant;
    logic       s1_overflow;
    logic       s2_overflow;

    uart_reply_arbiter #(
        .FIFO_DEPTH (FD),
        .MAX_LEN    (ML),
        .IDLE_CLKS  (IC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s1_rx_dv    (s1_rx_dv),
        .s1_rx_byte  (s1_rx_byte),
        .s2_rx_dv    (s2_rx_dv),
        .s2_rx_byte  (s2_rx_byte),
        .tx_busy     (tx_busy),
        .tx_dv       (tx_dv),
        .tx_byte     (tx_byte),
        .grant       (grant),
        .s1_overflow (s1_overflow),
        .s2_overflow (s2_overflow)
    );

    always #5 clk = ~clk;

    // Host UART_TX model: busy for busy_len clocks after each start strobe
    int unsigned busy_len = 4;
    int unsigned busy_cnt = 0;
    logic        hold_busy = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst) busy_cnt <= 0;
        else if (tx_dv) busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = hold_busy || (busy_cnt != 0);

    typedef struct {
        logic [7:0] b;
        logic [1:0] g;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int failures = 0;

    task automatic exp_byte(input logic [7:0] b, input logic [1:0] g);
        exp_t e;
        e.b = b;
        e.g = g;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: scoreboard compare plus handshake rules on every tx_dv
    logic       prev_dv = 1'b0;
    logic [7:0] last_byte = 8'h00;
    exp_t       mon_e;
    always @(negedge clk) begin
        if (rst) begin
            prev_dv   = 1'b0;
            last_byte = 8'h00;
        end else begin
            if (tx_dv) begin
                checks++;
                if (tx_busy || prev_dv) begin
                    failures++;
                    $display("FAIL handshake: tx_dv=1 with tx_busy=%b prev_dv=%b, required both 0",
                             tx_busy, prev_dv);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_byte: got byte %h grant %b, required no output",
                             tx_byte, grant);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (tx_byte !== mon_e.b || grant !== mon_e.g) begin
                        failures++;
                        $display("FAIL packet_byte: got byte %h grant %b, required byte %h grant %b",
                                 tx_byte, grant, mon_e.b, mon_e.g);
                    end
                end
                last_byte = tx_byte;
            end else if (tx_busy) begin
                checks++;
                if (tx_byte !== last_byte) begin
                    failures++;
                    $display("FAIL tx_byte_stable: got %h while busy, required %h",
                             tx_byte, last_byte);
                end
            end
            prev_dv = tx_dv;
        end
    end

    task automatic push(input int ch, input logic [7:0] b);
        @(posedge clk);
        #1;
        if (ch == 1) begin
            s1_rx_dv = 1'b1;
            s1_rx_byte = b;
        end else begin
            s2_rx_dv = 1'b1;
            s2_rx_byte = b;
        end
        @(posedge clk);
        #1;
        s1_rx_dv = 1'b0;
        s2_rx_dv = 1'b0;
    endtask

    task automatic push_both(input logic [7:0] b1, input logic [7:0] b2);
        @(posedge clk);
        #1;
        s1_rx_dv = 1'b1;
        s1_rx_byte = b1;
        s2_rx_dv = 1'b1;
        s2_rx_byte = b2;
        @(posedge clk);
        #1;
        s1_rx_dv = 1'b0;
        s2_rx_dv = 1'b0;
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || grant != 2'b00) && n < limit) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= limit) begin
            failures++;
            $display("FAIL %s: timeout with %0d bytes outstanding, required 0", name,
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation did not finish, required completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int n;
        logic found;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx_dv", tx_dv, 0);
        chk("reset_tx_byte", tx_byte, 0);
        chk("reset_grant", grant, 0);
        chk("reset_s1_ovf", s1_overflow, 0);
        chk("reset_s2_ovf", s2_overflow, 0);
        rst = 1'b0;

        // 1: partial packet flushed after idle, with header latency check
        busy_len = IC;
        exp_byte(8'h03, 2'b01);
        exp_byte(8'h11, 2'b01);
        exp_byte(8'h22, 2'b01);
        exp_byte(8'h33, 2'b01);
        push(1, 8'h11);
        repeat (BIT - 1) @(posedge clk);
        push(1, 8'h22);
        repeat (BIT - 1) @(posedge clk);
        push(1, 8'h33);
        repeat (IC) @(posedge clk);
        #2;
        chk("t1_grant_before_flush", grant, 2'b00);
        @(posedge clk);
        #2;
        chk("t1_grant_hdr", grant, 2'b01);
        chk("t1_dv_hdr_state", tx_dv, 0);
        @(posedge clk);
        #2;
        chk("t1_hdr_pulse", tx_dv, 1);
        drain("t1_drain", 6 * IC);
        chk("t1_grant_released", grant, 2'b00);

        // 2: 20 bytes on ch2 split into 16 + 4
        busy_len = 4;
        exp_byte(8'h50, 2'b10);
        for (int i = 0; i < 16; i++) exp_byte(8'(i), 2'b10);
        exp_byte(8'h44, 2'b10);
        for (int i = 16; i < 20; i++) exp_byte(8'(i), 2'b10);
        for (int i = 0; i < 20; i++) begin
            push(2, 8'(i));
            repeat (BIT - 1) @(posedge clk);
        end
        drain("t2_drain", 4 * IC);
        chk("t2_s2_ovf", s2_overflow, 0);

        // 3: round-robin tie after reset, then a second tie while ch1 holds the link
        do_reset();
        busy_len = IC;
        exp_byte(8'h02, 2'b01);
        exp_byte(8'hA1, 2'b01);
        exp_byte(8'hA2, 2'b01);
        exp_byte(8'h42, 2'b10);
        exp_byte(8'hB1, 2'b10);
        exp_byte(8'hB2, 2'b10);
        exp_byte(8'h01, 2'b01);
        exp_byte(8'hA3, 2'b01);
        push_both(8'hA1, 8'hB1);
        repeat (BIT - 1) @(posedge clk);
        push_both(8'hA2, 8'hB2);
        n = 0;
        while (grant == 2'b00 && n < 2 * IC) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t3_first_grant", grant, 2'b01);
        push(1, 8'hA3);
        drain("t3_drain", 12 * IC);

        // 4: overflow while the link is stalled
        busy_len = 4;
        hold_busy = 1'b1;
        exp_byte(8'h10, 2'b01);
        for (int i = 0; i < 16; i++) exp_byte(8'hC0 + 8'(i), 2'b01);
        for (int i = 0; i < 17; i++) push(1, 8'hC0 + 8'(i));
        chk("t4_s1_ovf_set", s1_overflow, 1);
        chk("t4_s2_ovf_clear", s2_overflow, 0);
        hold_busy = 1'b0;
        drain("t4_drain", 4 * IC);
        repeat (2 * IC) @(posedge clk);
        #1;
        chk("t4_s1_ovf_sticky", s1_overflow, 1);
        chk("t4_s2_ovf_final", s2_overflow, 0);

        // 6: reset during the second data byte of a 5-byte packet
        busy_len = IC;
        exp_byte(8'h05, 2'b01);
        exp_byte(8'hE1, 2'b01);
        exp_byte(8'hE2, 2'b01);
        for (int i = 1; i <= 5; i++) push(1, 8'hE0 + 8'(i));
        found = 1'b0;
        n = 0;
        while (!found && n < 5 * IC) begin
            @(posedge clk);
            #2;
            if (tx_dv && tx_byte == 8'hE2) found = 1'b1;
            n++;
        end
        chk("t6_second_data_seen", found, 1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_tx_dv", tx_dv, 0);
        chk("t6_rst_grant", grant, 2'b00);
        chk("t6_rst_tx_byte", tx_byte, 0);
        chk("t6_rst_s1_ovf", s1_overflow, 0);
        chk("t6_queue_at_rst", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        exp_byte(8'h43, 2'b10);
        exp_byte(8'hF1, 2'b10);
        exp_byte(8'hF2, 2'b10);
        exp_byte(8'hF3, 2'b10);
        push(2, 8'hF1);
        repeat (BIT - 1) @(posedge clk);
        push(2, 8'hF2);
        repeat (BIT - 1) @(posedge clk);
        push(2, 8'hF3);
        drain("t6_drain", 8 * IC);
        // Leftover ch1 bytes would surface here as unexpected output
        repeat (2 * IC) @(posedge clk);
        #1;
        chk("end_queue_empty", exp_q.size(), 0);
        chk("end_grant_idle", grant, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
